// File: rtl/gamepad_wb.sv
// gamepad_wb: Wishbone slave that polls two SNES/NES-style serial pads.
//
// Two shift-register controllers share gp_latch, gp_clk and gp_sel. Each pad
// drives its own bit of gp_data. A poll latches the pads, clocks N_BITS bits
// out of both, then publishes the two button words together in DATA.
// A poll starts on a CSR trigger, or automatically every POLL_DIV cycles.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   wb_addr/wb_wdata  register select / write data
//   wb_we, wb_cyc     write enable / cycle strobe for this slot
//   wb_ack, wb_rdata  one-cycle ack; read data is zero outside ack
//   gp_sel            pad select line, driven from CSR bit 2
//   gp_data           serial data (pad0=bit0, pad1=bit1), async, active-low
//   gp_latch          latch pulse, active-high
//   gp_clk            shift clock, idles high
//
// Registers:
//   0 CSR   W: [0] auto-enable, [1] trigger, [2] gp_sel
//           R: [0] auto-enable, [2] gp_sel, [14] new, [15] busy
//   1 DATA  R: [15:0] pad0, [31:16] pad1 (1 = pressed); a read clears new
//   2,3     read as zero, writes ignored
module gamepad_wb #(
    parameter int unsigned DIV      = 32,
    parameter int unsigned N_BITS   = 16,
    parameter int unsigned POLL_DIV = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        gp_sel,
    input  logic [1:0]  gp_data,
    output logic        gp_latch,
    output logic        gp_clk
);

    localparam int unsigned DIV_W  = $clog2(DIV);
    localparam int unsigned BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int unsigned POLL_W = $clog2(POLL_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CLK_LO,
        S_CLK_HI,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [1:0]          gp_meta_q;
    logic [1:0]          gp_sync_q;
    logic                ack_q;
    logic                ack_d;
    logic [31:0]         rdata_q;
    logic [31:0]         rdata_d;
    logic                auto_en_q;
    logic                sel_q;
    logic                new_q;
    logic [31:0]         data_q;
    logic                gp_latch_q;
    logic                gp_clk_q;
    logic [DIV_W-1:0]    div_q;
    logic                ph_q;
    logic [BIT_W-1:0]    bit_q;
    logic [N_BITS-1:0]   sh0_q;
    logic [N_BITS-1:0]   sh1_q;
    logic [POLL_W-1:0]   poll_q;
    logic [POLL_W-1:0]   poll_d;

    logic                busy;
    logic                tick;
    logic                poll_hit;
    logic                wr_csr;
    logic                rd_data;
    logic                start;
    logic [15:0]         pad0_w;
    logic [15:0]         pad1_w;

    // Only bits [2:0] of a write carry meaning.
    logic                unused_wdata;
    assign unused_wdata = ^wb_wdata[31:3];

    always_comb begin
        ack_d    = wb_cyc & ~ack_q;
        // Writes and the DATA-read side effect happen in the ack cycle.
        wr_csr   = ack_q & wb_cyc & wb_we & (wb_addr == 2'd0);
        rd_data  = ack_q & wb_cyc & ~wb_we & (wb_addr == 2'd1);
        busy     = (state_q != S_IDLE);
        tick     = (div_q == DIV_W'(DIV - 1));
        poll_hit = (poll_q == POLL_W'(POLL_DIV - 1));
        // A trigger or an auto expiry while busy is dropped, never queued.
        start    = ~busy & ((wr_csr & wb_wdata[1]) | (auto_en_q & poll_hit));

        rdata_d = '0;
        if (ack_d) begin
            case (wb_addr)
                2'd0: begin
                    rdata_d[0]  = auto_en_q;
                    rdata_d[2]  = sel_q;
                    rdata_d[14] = new_q;
                    rdata_d[15] = busy;
                end
                2'd1:    rdata_d = data_q;
                default: rdata_d = '0;
            endcase
        end

        if (!auto_en_q || poll_hit) begin
            poll_d = '0;
        end else begin
            poll_d = poll_q + 1'b1;
        end

        pad0_w = '0;
        pad1_w = '0;
        pad0_w[N_BITS-1:0] = ~sh0_q;
        pad1_w[N_BITS-1:0] = ~sh1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gp_meta_q  <= '1;
            gp_sync_q  <= '1;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            auto_en_q  <= 1'b0;
            sel_q      <= 1'b0;
            new_q      <= 1'b0;
            data_q     <= '0;
            gp_latch_q <= 1'b0;
            gp_clk_q   <= 1'b1;
            div_q      <= '0;
            ph_q       <= 1'b0;
            bit_q      <= '0;
            sh0_q      <= '0;
            sh1_q      <= '0;
            poll_q     <= '0;
        end else begin
            gp_meta_q <= gp_data;
            gp_sync_q <= gp_meta_q;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            poll_q    <= poll_d;

            if (wr_csr) begin
                auto_en_q <= wb_wdata[0];
                sel_q     <= wb_wdata[2];
            end

            // DONE below overrides this, so a coincident set wins.
            if (rd_data) begin
                new_q <= 1'b0;
            end

            div_q <= tick ? '0 : div_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    gp_latch_q <= 1'b0;
                    gp_clk_q   <= 1'b1;
                    div_q      <= '0;
                    if (start) begin
                        state_q    <= S_LATCH;
                        gp_latch_q <= 1'b1;
                        ph_q       <= 1'b0;
                        bit_q      <= '0;
                    end
                end
                S_LATCH: begin
                    if (tick) begin
                        if (ph_q) begin
                            state_q    <= S_CLK_LO;
                            gp_latch_q <= 1'b0;
                            gp_clk_q   <= 1'b0;
                        end else begin
                            ph_q <= 1'b1;
                        end
                    end
                end
                S_CLK_LO: begin
                    // Sample on the last low cycle, just before the rising
                    // edge that advances the pads to the next bit.
                    if (tick) begin
                        sh0_q[bit_q] <= gp_sync_q[0];
                        sh1_q[bit_q] <= gp_sync_q[1];
                        state_q      <= S_CLK_HI;
                        gp_clk_q     <= 1'b1;
                    end
                end
                S_CLK_HI: begin
                    if (tick) begin
                        if (bit_q == BIT_W'(N_BITS - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            state_q  <= S_CLK_LO;
                            gp_clk_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    data_q  <= {pad1_w, pad0_w};
                    new_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    gp_latch_q <= 1'b0;
                    gp_clk_q   <= 1'b1;
                end
            endcase
        end
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;
    assign gp_sel   = sel_q;
    assign gp_latch = gp_latch_q;
    assign gp_clk   = gp_clk_q;

endmodule

// File: doc/gamepad_wb.md
Name: gamepad_wb

Overview:
Wishbone slave that polls two serial shift-register game controllers (SNES/NES style) sharing latch, clock and select lines, with one data line per pad. It sits on a single slot of the USB-to-Wishbone bridge bus, downstream of the bridge, beside the I2C master. It generates the latch and clock waveforms, shifts in N_BITS per pad, and presents the two button words atomically to the host. Polling is either single-shot or automatic at a fixed rate.

Parameters:
DIV, 32, system clock cycles per gp_clk phase tick (minimum 4)
N_BITS, 16, bits shifted per pad per poll (1..16)
POLL_DIV, 200000, cycles between automatic polls (minimum (2+2*N_BITS)*DIV+2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wb_addr  in  2  register select
wb_wdata  in  32  write data
wb_rdata  out  32  read data, 0 when wb_ack=0
wb_we  in  1  write enable
wb_cyc  in  1  cycle strobe for this slave
wb_ack  out  1  single-cycle acknowledge
gp_sel  out  1  pad select / power-mode line, from CSR
gp_data  in  2  serial data, pad0=bit0, pad1=bit1, asynchronous, active-low buttons
gp_latch  out  1  latch pulse, active-high
gp_clk  out  1  shift clock, idles high

Behaviour:
- Reset values: wb_ack=0, wb_rdata=0, gp_latch=0, gp_clk=1, gp_sel=0, auto-enable=0, data reg=0, new flag=0, FSM=IDLE, poll counter=0.
- gp_data passes through a 2-FF synchronizer before use.
- Bus: wb_ack = wb_cyc & ~wb_ack, registered, so ack comes 1 cycle after cyc rises and lasts 1 cycle. Writes take effect on the ack cycle. wb_rdata is registered and valid only with ack, otherwise 0 (OR-bus).
- Address map:
  - 0 CSR.
    - W: bit0 auto-enable; bit1 trigger (self-clearing, never stored); bit2 gp_sel.
    - R: bit0 auto-enable; bit2 gp_sel; bit14 new; bit15 busy; other bits 0.
  - 1 DATA.
    - R: [15:0] pad0, [31:16] pad1. Bits are inverted so 1 = pressed. Bit k = k-th shifted bit, unused upper bits 0.
    - Reading DATA clears new on the ack cycle. Writes are ignored.
  - 2, 3: read 0, writes ignored.
- Tick divider: counter reset to 0 on poll start. Emits a tick strobe every DIV cycles.
- FSM:
  - IDLE: gp_latch=0, gp_clk=1. On start request go to LATCH and reset the tick divider and bit counter.
  - LATCH: gp_latch=1 for 2 ticks (2*DIV cycles), then go to CLK_LO.
  - CLK_LO: gp_clk=0 for 1 tick. On the final cycle, shift the synchronized gp_data[0] and gp_data[1] into the two shift registers, LSB-first (bit index = bit counter). Then go to CLK_HI.
  - CLK_HI: gp_clk=1 for 1 tick. If bit counter = N_BITS-1, go to DONE; else increment and go to CLK_LO.
  - DONE (1 cycle): copy both shift registers, inverted, into the DATA register in the same cycle. Set new=1, go to IDLE.
- busy = (FSM != IDLE).
- Total busy time = (2+2*N_BITS)*DIV + 1 cycles.
- Start request:
  - A CSR write with bit1=1 while IDLE.
  - Or, when auto-enable=1 and IDLE, the poll counter reaching POLL_DIV-1. The poll counter runs freely, wraps to 0, and is held at 0 while auto-enable=0.
  - Trigger while busy is ignored, with no queueing.
  - An auto expiry while busy is dropped; the next poll happens at the next wrap.
- Simultaneous DONE and DATA read-ack: the read returns the old data, and new ends at 1 (set wins).
- Writing CSR mid-poll updates auto-enable and gp_sel immediately and does not disturb the poll.
- rst mid-poll: abort immediately to reset values. The partial shift is discarded and DATA=0.

Test Plan:
- Reset -> gp_clk=1, gp_latch=0, gp_sel=0. Read addr0 = 0x00000000; read addr1 = 0x00000000. Each ack exactly 1 cycle, 1 cycle after cyc.
- DIV=4, N_BITS=16; pad0 model returns 0xA5C3, pad1 returns 0x0F0F (active-high pressed, driven inverted, LSB first). Write CSR=0x2 -> busy=1 for 137 cycles, 16 gp_clk low pulses of 4 cycles, latch high 8 cycles. Then DATA read = 0x0F0FA5C3, CSR bit14=1 before the read and 0 after it.
- Trigger write during a poll (cycle 50) -> no second poll; exactly 16 clock pulses observed.
- Auto mode, POLL_DIV=300: write CSR=0x1 -> poll starts every 300 cycles. Write CSR=0x0 -> no further polls after the current one completes.
- Assert rst at cycle 60 of a poll -> next cycle gp_clk=1, gp_latch=0, busy=0, DATA=0. A new trigger then completes normally.
- Read DATA in the exact DONE cycle -> returns the previous value, and CSR new bit reads 1 afterwards.
